// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and constants for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [15:0] TIMEOUT_ERR_DATA = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_WAIT_FINAL,
    ST_CAPTURE,
    ST_RESULT
  } state_t;

endpackage

// File: rtl/alu_seq_result_fmt.sv
// Normalises the raw ALU outbus into the 16-bit result word for the given opcode.
module alu_seq_result_fmt
  import alu_seq_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [15:0] i_raw,
  output logic [15:0] o_data
);

  always_comb begin
    o_data = i_raw;
    // add/sub leave an 8-bit signed result in the upper byte
    if (i_op == OP_ADD || i_op == OP_SUB) begin
      o_data = {{8{i_raw[15]}}, i_raw[15:8]};
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Turns one valid/ready command into the alu_top byte/start/final protocol and returns a 16-bit result.
// Optional watchdog on WAIT_FINAL is built only when ALU_SEQ_TIMEOUT_EN is defined.
//
// state       | meaning
// IDLE        | cmd_ready high, waiting for a command
// WAIT_RDY    | command latched, waiting for alu_ready
// S0          | start pulse, word0 on inbus
// S1          | word0 held
// S2          | word1 on inbus
// S3, S4      | div only: divisor on inbus for two cycles
// WAIT_FINAL  | last word held until alu_final
// CAPTURE     | outbus sampled and formatted
// RESULT      | res_valid high until res_ready
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_err,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  output logic [7:0]  alu_inbus,
  input  logic        alu_ready,
  input  logic        alu_final,
  input  logic [15:0] alu_outbus
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [7:0]  r_b;
  logic [15:0] r_res_data;
  logic [15:0] w_fmt;
  logic [7:0]  w_w0;
  logic [7:0]  w_w1;
  logic [7:0]  w_last;
  logic        w_accept;
  logic        w_timeout;

  // Held low while rst is asserted so the reset value of cmd_ready is 0
  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;

  // The ALU computes word1 - word0, so sub swaps the operands
  assign w_w0   = (r_op == OP_SUB) ? r_b : (r_op == OP_DIV) ? r_a[15:8] : r_a[7:0];
  assign w_w1   = (r_op == OP_SUB || r_op == OP_DIV) ? r_a[7:0] : r_b;
  assign w_last = (r_op == OP_DIV) ? r_b : w_w1;

  assign alu_op    = r_op;
  assign alu_start = (r_state == ST_S0);
  assign res_valid = (r_state == ST_RESULT);
  assign res_data  = r_res_data;

  always_comb begin
    w_next    = r_state;
    alu_inbus = 8'h00;
    case (r_state)
      ST_IDLE:     if (w_accept) w_next = ST_WAIT_RDY;
      ST_WAIT_RDY: if (alu_ready) w_next = ST_S0;
      ST_S0: begin
        alu_inbus = w_w0;
        w_next    = ST_S1;
      end
      ST_S1: begin
        alu_inbus = w_w0;
        w_next    = ST_S2;
      end
      ST_S2: begin
        alu_inbus = w_w1;
        w_next    = (r_op == OP_DIV) ? ST_S3 : ST_WAIT_FINAL;
      end
      ST_S3: begin
        alu_inbus = r_b;
        w_next    = ST_S4;
      end
      ST_S4: begin
        alu_inbus = r_b;
        w_next    = ST_WAIT_FINAL;
      end
      ST_WAIT_FINAL: begin
        alu_inbus = w_last;
        if (alu_final)      w_next = ST_CAPTURE;
        else if (w_timeout) w_next = ST_RESULT;
      end
      ST_CAPTURE: begin
        alu_inbus = w_last;
        w_next    = ST_RESULT;
      end
      ST_RESULT: begin
        alu_inbus = w_last;
        if (res_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= 2'b00;
      r_a        <= 16'h0000;
      r_b        <= 8'h00;
      r_res_data <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= cmd_op;
        r_a  <= cmd_a;
        r_b  <= cmd_b;
      end
      if (r_state == ST_CAPTURE) begin
        r_res_data <= w_fmt;
      end else if (w_timeout) begin
        r_res_data <= TIMEOUT_ERR_DATA;
      end
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_res_err;

  // A final arriving on the last allowed cycle still wins over the abort
  assign w_timeout = (r_state == ST_WAIT_FINAL) && !alu_final &&
                     (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign res_err   = r_res_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 16'h0000;
      r_res_err <= 1'b0;
    end else begin
      if (r_state == ST_WAIT_FINAL) r_cnt <= r_cnt + 16'd1;
      else                          r_cnt <= 16'h0000;
      if (w_timeout)                              r_res_err <= 1'b1;
      else if (r_state == ST_RESULT && res_ready) r_res_err <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign res_err   = 1'b0;
`endif

  alu_seq_result_fmt u_fmt (
    .i_op   (r_op),
    .i_raw  (alu_outbus),
    .o_data (w_fmt)
  );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised self-checking bench for alu_cmd_sequencer; the bench also plays the alu_top side.
// The timeout scenario is exercised only when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int TB_TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [7:0]  cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;
  logic [1:0]  alu_op;
  logic        alu_start;
  logic [7:0]  alu_inbus;
  logic        alu_ready;
  logic        alu_final;
  logic [15:0] alu_outbus;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .alu_op(alu_op), .alu_start(alu_start), .alu_inbus(alu_inbus),
    .alu_ready(alu_ready), .alu_final(alu_final), .alu_outbus(alu_outbus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected result straight from the arithmetic meaning of each command
  function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] a,
                                             input logic [7:0] b);
    int sa, sb, r, ua, ub;
    logic [7:0] t;
    sa = int'($signed(a[7:0]));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    case (op)
      OP_ADD: begin r = sa + sb; t = r[7:0]; return {{8{t[7]}}, t}; end
      OP_SUB: begin r = sa - sb; t = r[7:0]; return {{8{t[7]}}, t}; end
      OP_MUL: begin r = sa * sb; return r[15:0]; end
      default: begin
        if (ub == 0) return 16'hDEAD;
        return {8'(ua % ub), 8'(ua / ub)};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                        input int rdy_dly, input int fin_dly, input int stall,
                        input bit spurious, input bit no_final, input int fixed);
    logic [7:0]  exp_w[$];
    logic [7:0]  got_w[$];
    logic [15:0] exp_res, alu_res, dd;
    logic [7:0]  dv;
    logic        exp_err;
    bit          op_bad, start_bad, stall_bad, seq_bad;
    string       s_got, s_exp;
    int          n;
    op_bad = 0; start_bad = 0; stall_bad = 0; seq_bad = 0;
    case (op)
      OP_SUB: begin exp_w.push_back(b); exp_w.push_back(b); exp_w.push_back(a[7:0]); end
      OP_DIV: begin
        exp_w.push_back(a[15:8]); exp_w.push_back(a[15:8]); exp_w.push_back(a[7:0]);
        exp_w.push_back(b); exp_w.push_back(b);
      end
      default: begin exp_w.push_back(a[7:0]); exp_w.push_back(a[7:0]); exp_w.push_back(b); end
    endcase
    exp_res = (fixed >= 0) ? 16'(fixed) : ref_result(op, a, b);
    exp_err = 1'b0;
    if (no_final) begin exp_res = 16'hFFFF; exp_err = 1'b1; end

    alu_final = 0; cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; alu_ready = (rdy_dly == 0);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 0;
      return;
    end
    @(negedge clk);
    cmd_valid = 0;
    n = 1;
    while (alu_start !== 1'b1 && n < 40) begin
      if (alu_op !== op) op_bad = 1;
      alu_ready = (n >= 1 + rdy_dly);
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 2 + rdy_dly || alu_start !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: start after %0d cycles required %0d", n, 2 + rdy_dly);
      return;
    end
    alu_ready = 0;
    for (int k = 0; k < exp_w.size(); k++) begin
      if (k > 0) begin
        @(negedge clk);
        alu_final = 0;
        if (alu_start !== 1'b0) start_bad = 1;
      end
      got_w.push_back(alu_inbus);
      if (got_w[k] !== exp_w[k]) seq_bad = 1;
      if (alu_op !== op) op_bad = 1;
      // a final pulse while operands are still streaming must be ignored
      if (k == 0 && spurious) begin alu_final = 1; alu_outbus = 16'hBAD0; end
    end
    checks++;
    if (seq_bad) begin
      failures++;
      s_got = ""; s_exp = "";
      for (int k = 0; k < exp_w.size(); k++) begin
        s_got = {s_got, $sformatf("%h ", got_w[k])};
        s_exp = {s_exp, $sformatf("%h ", exp_w[k])};
      end
      $display("FAIL inbus_seq: op=%0d got %s required %s", op, s_got, s_exp);
    end
    checks++;
    if (start_bad) begin
      failures++;
      $display("FAIL start_pulse: alu_start high after first word, required single cycle");
    end

    // ALU behaviour built from the words it actually received
    case (op)
      OP_ADD: alu_res = {8'(got_w[0] + got_w[2]), 8'($urandom)};
      OP_SUB: alu_res = {8'(got_w[2] - got_w[0]), 8'($urandom)};
      OP_MUL: alu_res = 16'(int'($signed(got_w[0])) * int'($signed(got_w[2])));
      default: begin
        dd = {got_w[0], got_w[2]};
        dv = got_w[3];
        alu_res = (dv == 8'd0) ? 16'hDEAD : {8'(dd % 16'(dv)), 8'(dd / 16'(dv))};
      end
    endcase

    @(negedge clk);
    checks++;
    if (alu_inbus !== exp_w[$]) begin
      failures++;
      $display("FAIL inbus_hold: inbus=%h required %h", alu_inbus, exp_w[$]);
    end
    if (!no_final) begin
      for (int k = 0; k < fin_dly; k++) begin
        @(negedge clk);
        if (alu_op !== op) op_bad = 1;
      end
      alu_final = 1; alu_outbus = alu_res;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        alu_final = 0;
      end while (res_valid !== 1'b1 && n < 10);
      checks++;
      if (n !== 2) begin
        failures++;
        $display("FAIL result_latency: res_valid after %0d cycles required 2", n);
      end
    end else begin
      alu_outbus = 16'($urandom);
      n = 1;
      while (res_valid !== 1'b1 && n < TB_TO + 20) begin
        if (alu_op !== op) op_bad = 1;
        @(negedge clk);
        n++;
      end
      checks++;
      if (n !== TB_TO + 1) begin
        failures++;
        $display("FAIL timeout_latency: res_valid after %0d cycles required %0d", n, TB_TO + 1);
      end
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp_res) begin
      failures++;
      $display("FAIL result: op=%0d a=%h b=%h res_valid=%b res_data=%h required %h",
               op, a, b, res_valid, res_data, exp_res);
    end
    checks++;
    if (res_err !== exp_err) begin
      failures++;
      $display("FAIL res_err: got %b required %b", res_err, exp_err);
    end
    for (int k = 0; k < stall; k++) begin
      cmd_valid = 1; cmd_op = 2'($urandom); cmd_a = 16'($urandom); cmd_b = 8'($urandom);
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== exp_res || res_err !== exp_err || cmd_ready !== 1'b0)
        stall_bad = 1;
      if (alu_op !== op) op_bad = 1;
    end
    if (stall > 0) begin
      checks++;
      if (stall_bad) begin
        failures++;
        $display("FAIL stall_hold: res_data=%h cmd_ready=%b required %h and 0", res_data,
                 cmd_ready, exp_res);
      end
    end
    checks++;
    if (op_bad) begin
      failures++;
      $display("FAIL alu_op_stable: alu_op=%b required %b throughout", alu_op, op);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0; cmd_valid = 0; alu_ready = 1; alu_outbus = 16'($urandom);
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL handoff: res_valid=%b cmd_ready=%b res_err=%b required 0 1 0",
               res_valid, cmd_ready, res_err);
    end
  endtask

  task automatic test_reset();
    rst = 1; cmd_valid = 0; cmd_op = 2'b11; cmd_a = 16'h1234; cmd_b = 8'h56;
    res_ready = 0; alu_ready = 1; alu_final = 0; alu_outbus = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, res_valid, res_data, res_err, alu_op, alu_start, alu_inbus} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs: cmd_ready=%b res_valid=%b res_data=%h res_err=%b alu_op=%b start=%b inbus=%h required all 0",
               cmd_ready, res_valid, res_data, res_err, alu_op, alu_start, alu_inbus);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_directed();
    run_op(OP_ADD, 16'd60, 8'd55, 0, 0, 0, 0, 0, 16'h0073);
    run_op(OP_SUB, 16'd25, 8'hF1, 0, 1, 0, 0, 0, 16'h0028);
    run_op(OP_SUB, 16'd60, 8'd120, 1, 0, 0, 0, 0, 16'hFFC4);
    run_op(OP_MUL, 16'd50, 8'hF4, 0, 2, 0, 0, 0, 16'hFDA8);
    run_op(OP_DIV, 16'd1000, 8'd12, 0, 0, 0, 0, 0, 16'h0453);
  endtask

  task automatic test_backpressure();
    run_op(OP_MUL, 16'd60, 8'd60, 0, 1, 10, 0, 0, 16'h0E10);
  endtask

  task automatic test_div_by_zero();
    run_op(OP_DIV, 16'd500, 8'd0, 0, 0, 0, 1, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
             bit'($urandom_range(0, 1)), 1'b0, -1);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    cmd_valid = 1; cmd_op = OP_DIV; cmd_a = 16'd1000; cmd_b = 8'd12; alu_ready = 1;
    @(negedge clk);
    cmd_valid = 0;
    n = 1;
    while (alu_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (alu_start !== 1'b1) begin
      failures++;
      $display("FAIL midop_start: no alu_start within %0d cycles", n);
    end
    alu_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (alu_inbus !== 8'hE8) begin
      failures++;
      $display("FAIL midop_s2: inbus=%h required e8", alu_inbus);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, res_valid, res_data, res_err, alu_op, alu_start, alu_inbus} !== 30'd0) begin
      failures++;
      $display("FAIL midop_reset: cmd_ready=%b res_valid=%b res_data=%h res_err=%b alu_op=%b start=%b inbus=%h required all 0",
               cmd_ready, res_valid, res_data, res_err, alu_op, alu_start, alu_inbus);
    end
    rst = 0; alu_ready = 1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_idle: cmd_ready=%b res_valid=%b required 1 0", cmd_ready, res_valid);
    end
    run_op(OP_ADD, 16'd1, 8'd1, 0, 0, 0, 0, 0, 16'h0002);
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_op(OP_MUL, 16'd7, 8'd9, 0, 0, 2, 0, 1, -1);
    run_op(OP_ADD, 16'd3, 8'd4, 0, 0, 0, 0, 0, 16'h0007);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_div_by_zero();
    test_random();
    test_reset_midop();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Front-end stage directly upstream and downstream of alu_top.
- Accepts one complete operation per valid/ready handshake: opcode plus full-width operands.
- Serialises the operands onto the ALU 8-bit inbus using the ALU start/ready protocol, waits for final, then captures outbus.
- Returns a normalised 16-bit result through a valid/ready result port, so callers never sequence the ALU byte protocol themselves.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT_FINAL before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
- cmd_a  in  16  add/sub/mul: signed operand A in [7:0]; div: unsigned 16-bit dividend
- cmd_b  in  8  operand B (signed for add/sub/mul, unsigned divisor for div)
- res_valid  out  1  result present
- res_ready  in  1  consumer takes result
- res_data  out  16  normalised result
- res_err  out  1  timeout abort flag (constant 0 without the macro)
- alu_op  out  2  to alu_top op
- alu_start  out  1  to alu_top start
- alu_inbus  out  8  to alu_top inbus
- alu_ready  in  1  from alu_top ready
- alu_final  in  1  from alu_top final
- alu_outbus  in  16  from alu_top outbus

Behaviour:
- Interface rule: one clock (clk); rst is synchronous and active-high.
- Reset values: cmd_ready=0, res_valid=0, res_data=0, res_err=0, alu_op=00, alu_start=0, alu_inbus=0; state=IDLE.
- cmd_ready=1 only in IDLE.
- Accept: cmd_valid & cmd_ready at a rising edge. Latch op, A and B. Go to WAIT_RDY.
- alu_op drives the latched op from the accept cycle until return to IDLE; it never changes while the ALU is busy.
- Operand word order (the ALU computes word1 - word0 for sub):
  - add/mul: w0=A[7:0], w1=B.
  - sub: w0=B, w1=A[7:0], so res = A - B.
  - div: w0=A[15:8], w1=A[7:0], w2=B.
- States, one cycle each unless noted:
  - WAIT_RDY: hold until alu_ready=1.
  - S0: alu_start=1, inbus=w0.
  - S1: alu_start=0, inbus=w0.
  - S2: inbus=w1.
  - Div only: S3 and S4: inbus=w2 (held 2 cycles).
  - WAIT_FINAL: inbus holds its last word until alu_final=1.
  - CAPTURE: one cycle after final is seen. Sample alu_outbus and format it.
  - RESULT: res_valid=1 until res_ready=1 at an edge, then IDLE.
- Command-to-first-start latency: 2 cycles when alu_ready is already 1 at accept.
- Formatting:
  - add/sub: res_data = sign-extended alu_outbus[15:8].
  - mul: alu_outbus verbatim (signed 16-bit product).
  - div: {remainder=alu_outbus[15:8], quotient=alu_outbus[7:0]} verbatim.
- res_data and res_err are stable while res_valid=1 and res_ready=0.
- res_valid & res_ready in the same cycle returns to IDLE. A new command can be accepted the following cycle; no bypass into a full RESULT.
- cmd_valid while busy is ignored (cmd_ready=0). No queueing.
- alu_final outside WAIT_FINAL is ignored.
- rst in any state: immediate return to IDLE with reset output values. A result held in RESULT is discarded.
- Divisor 0: passed through unchanged. Result is whatever the ALU returns; no error raised.

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit or wider counter clears on entry to WAIT_FINAL and increments each cycle there.
  - Reaching TIMEOUT_CYCLES with no alu_final: go to RESULT with res_data=16'hFFFF and res_err=1.
  - res_err clears when the sequencer leaves RESULT.
- Not defined: no counter is built, res_err is tied 0, and WAIT_FINAL waits indefinitely.

Decomposition:
- Package alu_seq_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - state enumeration;
  - TIMEOUT_ERR_DATA = 16'hFFFF.
- One natural combinational sub-module: alu_seq_result_fmt (op, raw outbus -> res_data).
- The FSM, operand latches and timeout counter stay in the top.

Test Plan:
- add A=60, B=55, res_ready=1 -> inbus sequence 3C,3C,37 with alu_start high only on the first; res_data=0x0073, res_err=0.
- sub A=25, B=-15 -> inbus F1,F1,19; res_data=0x0028. Then sub A=60, B=120 -> res_data=0xFFC4 (-60).
- mul A=50, B=-12 -> res_data=0xFDA8 (-600). alu_op stays 10 from accept through RESULT.
- div A=1000, B=12 -> inbus 03,03,E8,0C,0C; res_data=0x0453 (remainder 4, quotient 83).
- Back-pressure: hold res_ready=0 for 10 cycles after mul 60*60 -> res_data=0x0E10 stable, cmd_ready=0. A cmd_valid offered during the stall is not accepted until 1 cycle after res_ready.
- Reset mid-op: assert rst during S2 of a div -> next edge all outputs at reset values, IDLE. Following add 1+1 -> 0x0002. With ALU_SEQ_TIMEOUT_EN and alu_final forced 0 -> res_err=1, res_data=0xFFFF after TIMEOUT_CYCLES in WAIT_FINAL.
